// File: rtl/fp16_post_normalizer.sv
// Post-normalization stage for the binary16 adder: one left shift per cycle, valid/ready on
// both sides. Define FP16_NORM_RNE_EN to round the carry path to nearest-even (else truncate).
module fp16_post_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [4:0]  in_exp,
  input  logic [10:0] in_mant,
  input  logic        in_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inx
);

  typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

  state_e      state_q;
  logic        sign_q;
  logic        carry_q;
  logic [5:0]  exp_q;
  logic [10:0] mant_q;
  logic [15:0] result_q;
  logic        ovf_q, unf_q, inx_q;

  logic        fin_d;
  logic [15:0] res_d;
  logic        ovf_d, unf_d, inx_d;
  logic        guard;
  logic [9:0]  frac_w;
  logic [5:0]  exp_w;
`ifdef FP16_NORM_RNE_EN
  logic [10:0] rnd;
`endif

  // One NORM step: either finish with a result or request another left shift.
  always_comb begin
    guard  = mant_q[0];
    frac_w = mant_q[10:1];  // hidden bit after the right shift is the carry itself
    exp_w  = exp_q + 6'd1;
`ifdef FP16_NORM_RNE_EN
    rnd = '0;
    if (guard && frac_w[0]) begin
      rnd    = {1'b0, frac_w} + 11'd1;
      frac_w = rnd[9:0];
      if (rnd[10]) exp_w = exp_w + 6'd1;  // 1.111..1 rounded up to 10.000..0
    end
`endif
    fin_d = 1'b1;
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    if (exp_q == 6'd31) begin
      res_d = {sign_q, 5'h1f, 10'h000};
      ovf_d = 1'b1;
    end else if (carry_q) begin
      inx_d = guard;
      if (exp_w >= 6'd31) begin
        res_d = {sign_q, 5'h1f, 10'h000};
        ovf_d = 1'b1;
      end else begin
        res_d = {sign_q, exp_w[4:0], frac_w};
      end
    end else if (mant_q == 11'd0 || exp_q == 6'd0) begin
      res_d = 16'h0000;
    end else if (mant_q[10]) begin
      res_d = {sign_q, exp_q[4:0], mant_q[9:0]};
    end else if (exp_q == 6'd1) begin
      res_d = {sign_q, 15'h0000};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      fin_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= {1'b0, in_exp};
            mant_q  <= in_mant;
            carry_q <= in_carry;
            state_q <= StNorm;
          end
        end
        StNorm: begin
          if (fin_d) begin
            result_q <= res_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
            state_q  <= StDone;
          end else begin
            mant_q <= {mant_q[9:0], 1'b0};
            exp_q  <= exp_q - 6'd1;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_ovf    = ovf_q;
  assign out_unf    = unf_q;
  assign out_inx    = inx_q;

endmodule
